ram_latency_model: RTL and testbench

- Simulation and FPGA main-memory model on the RAM side of the CPU/RAM boundary.
- Consumes the address, store data and read/write enables that the single-cycle top block drives out of its memory controller.
- Returns load data and a handshake state after a programmable number of wait cycles.
- Lets the caches and memory controller be exercised against realistic, non-zero memory latency.

---
 rtl/cpu_types_pkg.sv | 14 +
 rtl/ram_latency_model_ram_array.sv | 24 ++
 rtl/ram_latency_model.sv | 136 +++++++++++++
 tb/tb_ram_latency_model.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU/RAM boundary types.
// Word and RAM handshake state used on both sides.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

endpackage

// File: rtl/ram_latency_model_ram_array.sv
// Word storage for the latency model.
// Synchronous write, synchronous (registered) read.
import cpu_types_pkg::*;

module ram_array #(
   parameter int DEPTH = 4096,
   parameter int AW    = 12
) (
   input  logic          CLK,
   input  logic          we,
   input  logic [AW-1:0] widx,
   input  word_t         wdata,
   output word_t         rdata
);

   word_t r_mem [DEPTH];

   // Write on we; always read the addressed word one edge later.
   always_ff @(posedge CLK) begin
      if (we) r_mem[widx] <= wdata;
      rdata <= r_mem[widx];
   end

endmodule

// File: rtl/ram_latency_model.sv
// Main-memory model with programmable wait cycles.
// Captures one request, waits LAT+1 BUSY cycles, then ACCESS.
import cpu_types_pkg::*;

module ram_latency_model #(
   parameter int LAT   = 2,
   parameter int DEPTH = 4096,
   parameter int AW    = 12
) (
   input  logic      CLK,
   input  logic      RST,
   input  word_t     ramaddr,
   input  word_t     ramstore,
   input  logic      ramREN,
   input  logic      ramWEN,
   output word_t     ramload,
   output ramstate_t ramstate
);

   typedef enum logic [1:0] {IDLE, WAIT, DONE, ERR} fsm_t;

   localparam logic [3:0] LAT4 = 4'(LAT);

   fsm_t          r_state;
   fsm_t          w_next;
   logic [3:0]    r_cnt;
   logic [3:0]    w_cnt_nxt;
   word_t         r_addr;
   word_t         r_data;
   logic          r_ren;
   logic          r_wen;
   word_t         r_load;
   ramstate_t     r_rs;
   ramstate_t     w_rs;
   logic          w_cap;
   logic          w_fin;
   logic          w_we;
   logic          w_bad;
   logic          w_abort;
   logic [AW-1:0] w_idx;
   word_t         w_rdata;

   // Address bits above the array are not backed by storage.
   assign w_bad = (ramaddr >> (AW + 2)) != 32'd0;

   // Any change of the held request (store data excluded) cancels it.
   assign w_abort = (ramaddr != r_addr) | (ramREN != r_ren) |
                    (ramWEN != r_wen) | ~(ramREN | ramWEN);

   // Read the incoming word at capture so LAT=0 still has data ready.
   assign w_idx = (r_state == IDLE) ? ramaddr[AW+1:2] : r_addr[AW+1:2];

   // Next state, counter, completion strobe and reported state.
   always_comb begin
      w_next    = r_state;
      w_cnt_nxt = r_cnt;
      w_cap     = 1'b0;
      w_fin     = 1'b0;
      w_we      = 1'b0;
      w_rs      = FREE;
      unique case (r_state)
         IDLE: begin
            if (ramREN & ramWEN) begin
               w_next = ERR;
            end else if ((ramREN | ramWEN) & w_bad) begin
               w_next = ERR;
            end else if (ramREN ^ ramWEN) begin
               w_cap     = 1'b1;
               w_cnt_nxt = LAT4;
               w_next    = WAIT;
            end
         end
         WAIT: begin
            if (w_abort) begin
               w_next = IDLE;
            end else if (r_cnt == 4'd0) begin
               w_next = DONE;
               w_fin  = 1'b1;
               w_we   = r_wen & ~RST;
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         DONE:    w_next = IDLE;
         ERR:     w_next = IDLE;
         default: w_next = IDLE;
      endcase
      unique case (w_next)
         IDLE:    w_rs = FREE;
         WAIT:    w_rs = BUSY;
         DONE:    w_rs = ACCESS;
         ERR:     w_rs = ERROR;
         default: w_rs = FREE;
      endcase
   end

   // State, counter, captured request and registered outputs.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= IDLE;
         r_cnt   <= 4'd0;
         r_addr  <= '0;
         r_data  <= '0;
         r_ren   <= 1'b0;
         r_wen   <= 1'b0;
         r_load  <= '0;
         r_rs    <= FREE;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_nxt;
         r_rs    <= w_rs;
         if (w_cap) begin
            r_addr <= ramaddr;
            r_data <= ramstore;
            r_ren  <= ramREN;
            r_wen  <= ramWEN;
         end
         if (w_fin & r_ren) r_load <= w_rdata;
      end
   end

   ram_array #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_array (
      .CLK   (CLK),
      .we    (w_we),
      .widx  (w_idx),
      .wdata (r_data),
      .rdata (w_rdata)
   );

   assign ramload  = r_load;
   assign ramstate = r_rs;

endmodule

// File: tb/tb_ram_latency_model.sv
// Bench for ram_latency_model: two instances, LAT=2 and LAT=0.
// Reference keeps a word array and the expected last read value.
import cpu_types_pkg::*;

module tb_ram_latency_model;

   logic        clk;
   logic        rst  [2];
   logic        ren  [2];
   logic        wen  [2];
   logic [31:0] addr [2];
   logic [31:0] wd   [2];
   logic [31:0] ld   [2];
   ramstate_t   st   [2];

   int          n_cmp;
   int          n_bad;
   int          lat  [2];
   logic [31:0] mdl  [2][4096];
   logic [31:0] exp_ld [2];

   ram_latency_model #(.LAT(2), .DEPTH(4096), .AW(12)) u0 (
      .CLK(clk), .RST(rst[0]), .ramaddr(addr[0]), .ramstore(wd[0]),
      .ramREN(ren[0]), .ramWEN(wen[0]), .ramload(ld[0]), .ramstate(st[0])
   );

   ram_latency_model #(.LAT(0), .DEPTH(4096), .AW(12)) u1 (
      .CLK(clk), .RST(rst[1]), .ramaddr(addr[1]), .ramstore(wd[1]),
      .ramREN(ren[1]), .ramWEN(wen[1]), .ramload(ld[1]), .ramstate(st[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Called at a negedge; drives request, counts BUSY cycles (bounded),
   // reports the state after them, load there, and state one cycle later.
   task automatic run_txn(input int s, input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] d,
                          output int n, output ramstate_t s1,
                          output ramstate_t s2, output logic [31:0] l);
      ren[s] = r; wen[s] = w; addr[s] = a; wd[s] = d;
      @(negedge clk);
      n = 0;
      while (st[s] == BUSY && n < 20) begin
         n++;
         @(negedge clk);
      end
      s1 = st[s];
      l  = ld[s];
      @(negedge clk);
      s2 = st[s];
      ren[s] = 1'b0; wen[s] = 1'b0; addr[s] = '0; wd[s] = '0;
   endtask

   task automatic test_reset();
      for (int c = 0; c < 6; c++) begin
         if (c == 3) begin rst[0] = 1'b0; rst[1] = 1'b0; end
         @(negedge clk);
         for (int s = 0; s < 2; s++) begin
            n_cmp++;
            if (st[s] !== FREE || ld[s] !== 32'd0) begin
               n_bad++;
               $display("FAIL reset dut%0d cyc%0d st=%0d ld=%h exp st=0 ld=0",
                        s, c, st[s], ld[s]);
            end
         end
      end
   endtask

   task automatic test_write_read();
      int n; ramstate_t s1, s2; logic [31:0] l;
      run_txn(0, 1'b0, 1'b1, 32'h40, 32'hDEADBEEF, n, s1, s2, l);
      mdl[0][16] = 32'hDEADBEEF;
      n_cmp++;
      if (n != 3 || s1 !== ACCESS || s2 !== FREE || l !== exp_ld[0]) begin
         n_bad++;
         $display("FAIL wr40 busy=%0d st=%0d/%0d ld=%h exp 3 2/0 %h",
                  n, s1, s2, l, exp_ld[0]);
      end
      run_txn(0, 1'b1, 1'b0, 32'h40, 32'h0, n, s1, s2, l);
      exp_ld[0] = mdl[0][16];
      n_cmp++;
      if (n != 3 || s1 !== ACCESS || s2 !== FREE || l !== 32'hDEADBEEF) begin
         n_bad++;
         $display("FAIL rd40 busy=%0d st=%0d/%0d ld=%h exp 3 2/0 deadbeef",
                  n, s1, s2, l);
      end
   endtask

   task automatic test_lat0();
      int n; ramstate_t s1, s2; logic [31:0] l;
      run_txn(1, 1'b1, 1'b0, 32'h100, 32'h0, n, s1, s2, l);
      exp_ld[1] = mdl[1][64];
      n_cmp++;
      if (n != 1 || s1 !== ACCESS || s2 !== FREE || l !== 32'd0) begin
         n_bad++;
         $display("FAIL lat0_rd100 busy=%0d st=%0d/%0d ld=%h exp 1 2/0 0",
                  n, s1, s2, l);
      end
   endtask

   task automatic test_error();
      int n; ramstate_t s1, s2; logic [31:0] l;
      run_txn(0, 1'b1, 1'b1, 32'h40, 32'h1111, n, s1, s2, l);
      n_cmp++;
      if (n != 0 || s1 !== ERROR || s2 !== FREE || ld[0] !== exp_ld[0]) begin
         n_bad++;
         $display("FAIL err_both busy=%0d st=%0d/%0d ld=%h exp 0 3/0 %h",
                  n, s1, s2, ld[0], exp_ld[0]);
      end
      run_txn(0, 1'b0, 1'b1, 32'h0001_0000, 32'h99, n, s1, s2, l);
      n_cmp++;
      if (n != 0 || s1 !== ERROR || s2 !== FREE || ld[0] !== exp_ld[0]) begin
         n_bad++;
         $display("FAIL err_addr_wr busy=%0d st=%0d/%0d ld=%h exp 0 3/0 %h",
                  n, s1, s2, ld[0], exp_ld[0]);
      end
      run_txn(1, 1'b1, 1'b0, 32'h0001_0000, 32'h0, n, s1, s2, l);
      n_cmp++;
      if (n != 0 || s1 !== ERROR || s2 !== FREE || ld[1] !== exp_ld[1]) begin
         n_bad++;
         $display("FAIL err_addr_rd busy=%0d st=%0d/%0d ld=%h exp 0 3/0 %h",
                  n, s1, s2, ld[1], exp_ld[1]);
      end
      run_txn(0, 1'b1, 1'b0, 32'h0, 32'h0, n, s1, s2, l);
      exp_ld[0] = mdl[0][0];
      n_cmp++;
      if (n != 3 || s1 !== ACCESS || l !== mdl[0][0]) begin
         n_bad++;
         $display("FAIL err_nowrite busy=%0d st=%0d ld=%h exp 3 2 %h",
                  n, s1, l, mdl[0][0]);
      end
      run_txn(0, 1'b1, 1'b0, 32'h40, 32'h0, n, s1, s2, l);
      exp_ld[0] = mdl[0][16];
      n_cmp++;
      if (l !== mdl[0][16]) begin
         n_bad++;
         $display("FAIL err_keep40 ld=%h exp %h", l, mdl[0][16]);
      end
   endtask

   task automatic test_abort();
      int n; ramstate_t s1, s2; logic [31:0] l;
      run_txn(0, 1'b0, 1'b1, 32'h44, 32'hCAFEF00D, n, s1, s2, l);
      mdl[0][17] = 32'hCAFEF00D;
      ren[0] = 1'b1; addr[0] = 32'h40;
      @(negedge clk);
      n_cmp++;
      if (st[0] !== BUSY) begin
         n_bad++;
         $display("FAIL abort_busy1 st=%0d exp 1", st[0]);
      end
      @(negedge clk);
      addr[0] = 32'h44;
      @(negedge clk);
      n_cmp++;
      if (st[0] !== FREE || ld[0] !== exp_ld[0]) begin
         n_bad++;
         $display("FAIL abort_free st=%0d ld=%h exp 0 %h",
                  st[0], ld[0], exp_ld[0]);
      end
      ren[0] = 1'b0; addr[0] = '0;
      run_txn(0, 1'b1, 1'b0, 32'h44, 32'h0, n, s1, s2, l);
      exp_ld[0] = mdl[0][17];
      n_cmp++;
      if (n != 3 || s1 !== ACCESS || s2 !== FREE || l !== 32'hCAFEF00D) begin
         n_bad++;
         $display("FAIL abort_rereq busy=%0d st=%0d/%0d ld=%h exp 3 2/0 cafef00d",
                  n, s1, s2, l);
      end
   endtask

   task automatic test_reset_mid_write();
      int n; ramstate_t s1, s2; logic [31:0] l;
      run_txn(0, 1'b0, 1'b1, 32'h80, 32'h12345678, n, s1, s2, l);
      mdl[0][32] = 32'h12345678;
      wen[0] = 1'b1; addr[0] = 32'h80; wd[0] = 32'h55;
      @(negedge clk);
      rst[0] = 1'b1;
      @(negedge clk);
      exp_ld[0] = 32'd0;
      n_cmp++;
      if (st[0] !== FREE || ld[0] !== 32'd0) begin
         n_bad++;
         $display("FAIL rst_mid st=%0d ld=%h exp 0 0", st[0], ld[0]);
      end
      rst[0] = 1'b0; wen[0] = 1'b0; addr[0] = '0; wd[0] = '0;
      run_txn(0, 1'b1, 1'b0, 32'h80, 32'h0, n, s1, s2, l);
      exp_ld[0] = mdl[0][32];
      n_cmp++;
      if (n != 3 || s1 !== ACCESS || l !== 32'h12345678) begin
         n_bad++;
         $display("FAIL rst_mid_rd busy=%0d st=%0d ld=%h exp 3 2 12345678",
                  n, s1, l);
      end
   endtask

   task automatic test_back_to_back();
      int n; ramstate_t s1, s2; logic [31:0] l;
      for (int k = 0; k < 40; k++) begin
         int s, wi;
         logic w;
         logic [31:0] a, d;
         s  = int'($urandom_range(0, 1));
         w  = 1'($urandom_range(0, 1));
         wi = int'($urandom_range(0, 15));
         a  = (32'(wi) << 2) | 32'($urandom_range(0, 3));
         d  = $urandom;
         run_txn(s, ~w, w, a, d, n, s1, s2, l);
         n_cmp++;
         if (n != lat[s] + 1 || s1 !== ACCESS || s2 !== FREE ||
             l !== (w ? exp_ld[s] : mdl[s][wi])) begin
            n_bad++;
            $display("FAIL b2b%0d dut%0d w=%0d a=%h busy=%0d st=%0d/%0d ld=%h exp %0d 2/0 %h",
                     k, s, w, a, n, s1, s2, l, lat[s] + 1,
                     w ? exp_ld[s] : mdl[s][wi]);
         end
         if (w) mdl[s][wi] = d;
         else   exp_ld[s] = mdl[s][wi];
      end
   endtask

   initial begin
      n_cmp = 0; n_bad = 0;
      lat[0] = 2; lat[1] = 0;
      for (int s = 0; s < 2; s++) begin
         rst[s] = 1'b1; ren[s] = 1'b0; wen[s] = 1'b0;
         addr[s] = '0; wd[s] = '0; exp_ld[s] = '0;
         for (int i = 0; i < 4096; i++) mdl[s][i] = '0;
      end
      test_reset();
      test_write_read();
      test_lat0();
      test_error();
      test_abort();
      test_reset_mid_write();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
